mult_datapath: RTL
==================

# mult_datapath

Shift-add multiplier datapath that executes the commands issued by the multiplier control unit. It captures two signed operands, performs one shift-add step per enabled cycle on their magnitudes, and reports the `z_flag`/`b0` status the controller sequences on. On completion it presents a signed 2·WIDTH-bit product to the BCD/seven-segment display path.

## Interface
- WIDTH, 8, operand width in bits (two's complement); product is 2·WIDTH bits
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- load  input  1  capture operands and start a new multiplication; priority over `enable`
- enable  input  1  perform one shift-add step this cycle (ignored unless RUN)
- multiplicand_in  input  WIDTH  signed multiplicand
- multiplier_in  input  WIDTH  signed multiplier
- product  output  2·WIDTH  signed result register, updated only at completion
- z_flag  output  1  magnitude multiplier register == 0 (combinational from register)
- b0  output  1  LSB of magnitude multiplier register
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on entry to DONE
- step_count  output  $clog2(WIDTH+1)  enabled steps executed since last load

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Registers: mcand (2·WIDTH, unsigned), mplier (WIDTH, unsigned), acc (2·WIDTH), sign (1), step_count, product.
- load (any state): mcand <= |multiplicand_in| zero-extended; mplier <= |multiplier_in|; acc <= 0; sign <= MSB(multiplicand_in) XOR MSB(multiplier_in); step_count <= 0; state <= RUN. product unchanged.
- Magnitude: |x| = x[WIDTH-1] ? (~x + 1) : x, taken as WIDTH-bit unsigned; |−2^(WIDTH-1)| = 2^(WIDTH-1) is representable, no overflow.
- RUN, load=0, evaluated on current register values:
  - z_flag=1 -> product <= sign ? −acc : acc (2·WIDTH two's complement); state <= DONE; done pulses. Independent of enable.
  - z_flag=0, enable=1 -> if b0: acc <= acc + mcand (mod 2^(2·WIDTH), cannot overflow for valid magnitudes); mcand <= mcand << 1; mplier <= mplier >> 1; step_count <= step_count + 1.
  - z_flag=0, enable=0 -> hold all registers.
- IDLE/DONE: enable ignored; all registers hold; only load leaves.
- step_count never exceeds WIDTH (mplier empties after at most WIDTH shifts).
- Zero operand result: sign forced irrelevant; −0 = 0, product = 0.

## Timing
- Reset values: product=0, z_flag=1 (mplier=0), b0=0, busy=0, done=0, step_count=0, state IDLE.
- load at edge k: busy=1, z_flag/b0 reflect |multiplier_in| after edge k.
- With enable held high: enabled steps = bit position of highest set bit of |multiplier| + 1 (0 if multiplier=0); one further edge finalizes. product valid and done=1 after edge k + steps + 1; busy falls same edge.
- done high exactly one cycle; product holds until next completion or reset.
- load and enable same cycle: load wins, no step taken.
- load during RUN: restart, in-flight result discarded, product keeps previous value, no done pulse.
- reset mid-operation: immediate (asynchronous) return to reset values, including product=0.
- z_flag and b0 are combinational from registers, no extra latency; controller samples them the cycle after the updating edge.

## Test plan
- Reset asserted mid-idle, then released -> product=0x0000, z_flag=1, b0=0, busy=0, done=0, step_count=0.
- load 5×3, enable held high -> b0 sequence 1,1; 2 steps; done pulse 3 edges after load; product=0x000F, step_count=2.
- load −7×6 (0xF9, 0x06), enable high -> product=0xFFD6 (−42), done 4 edges after load, step_count=3.
- load −128×−128 (0x80, 0x80), enable high -> 8 steps, product=0x4000, done 9 edges after load, step_count=8.
- load 25×0 -> z_flag=1 immediately, done pulses 1 edge after load with enable low, product=0x0000, step_count=0.
- load 9×9, drop enable for 3 cycles after first step (registers frozen, busy=1), then re-load 2×2 mid-run -> previous product retained until done, final product=0x0004; separately, reset asserted mid-run -> all outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/mult_datapath_if.sv
// Command/status bundle between the multiplier control unit (master)
// and the shift-add multiplier datapath (slave).
interface mult_datapath_if #(
  parameter int WIDTH = 8
);
  localparam int SCW = $clog2(WIDTH + 1);

  logic                 load;
  logic                 enable;
  logic [WIDTH-1:0]     multiplicand_in;
  logic [WIDTH-1:0]     multiplier_in;
  logic [2*WIDTH-1:0]   product;
  logic                 z_flag;
  logic                 b0;
  logic                 busy;
  logic                 done;
  logic [SCW-1:0]       step_count;

  modport master (
    output load, enable, multiplicand_in, multiplier_in,
    input  product, z_flag, b0, busy, done, step_count
  );

  modport slave (
    input  load, enable, multiplicand_in, multiplier_in,
    output product, z_flag, b0, busy, done, step_count
  );
endinterface

// File: rtl/mult_datapath.sv
// Signed shift-add multiplier datapath. Operands are reduced to magnitudes
// on load, one shift-add step is taken per enabled cycle, and the sign is
// reapplied when the multiplier register empties.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  mult_datapath_if.slave bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int SCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q,   state_d;
  logic [PW-1:0]    mcand_q,   mcand_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic             sign_q,    sign_d;
  logic [SCW-1:0]   step_q,    step_d;
  logic             done_q,    done_d;
  logic             z_w;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    magnitude = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign z_w = (mplier_q == '0);

  // Next-state and datapath update; load overrides everything else.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    step_d    = step_q;
    done_d    = 1'b0;
    if (bus.load) begin
      mcand_d  = {{WIDTH{1'b0}}, magnitude(bus.multiplicand_in)};
      mplier_d = magnitude(bus.multiplier_in);
      acc_d    = '0;
      sign_d   = bus.multiplicand_in[WIDTH-1] ^ bus.multiplier_in[WIDTH-1];
      step_d   = '0;
      state_d  = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (z_w) begin
            // Finalize regardless of enable: no multiplier bits remain.
            product_d = sign_q ? (~acc_q + PW'(1)) : acc_q;
            state_d   = DONE;
            done_d    = 1'b1;
          end else if (bus.enable) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + SCW'(1);
          end
        end
        default: ;  // IDLE and DONE hold until the next load
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      step_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
      step_q    <= step_d;
      done_q    <= done_d;
    end
  end

  assign bus.product    = product_q;
  assign bus.z_flag     = z_w;
  assign bus.b0         = mplier_q[0];
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.step_count = step_q;
endmodule
